// File: rtl/mem_pkg.sv
// Shared MEM-stage types: zip layouts, field indices and load-op encodings.
// Optional sub-word load support is enabled by defining MEM_LD_EXT_EN.
package mem_pkg;

  localparam int ZIP_ES_W = 39;
  localparam int ZIP_MS_W = 38;

  localparam int ES_MEM_BIT = 38;
  localparam int ES_WE_BIT  = 37;
  localparam int ES_WA_LSB  = 32;
  localparam int MS_WE_BIT  = 37;
  localparam int MS_WA_LSB  = 32;

  localparam logic [2:0] MEM_OP_LW  = 3'b000;
  localparam logic [2:0] MEM_OP_LB  = 3'b001;
  localparam logic [2:0] MEM_OP_LBU = 3'b010;
  localparam logic [2:0] MEM_OP_LH  = 3'b011;
  localparam logic [2:0] MEM_OP_LHU = 3'b100;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } es_zip_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] wdata;
  } ms_zip_t;

endpackage

// File: rtl/mem_ld_align.sv
// Load lane select and sign/zero extension for sub-word loads.
// Used by mem_stage only when MEM_LD_EXT_EN is defined.
module mem_ld_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (addr)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
  end

  // halfword lane ignores addr[0]
  assign h = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    unique case (op)
      MEM_OP_LB:  data = {{24{b[7]}}, b};
      MEM_OP_LBU: data = {24'h0, b};
      MEM_OP_LH:  data = {{16{h[15]}}, h};
      MEM_OP_LHU: data = {16'h0, h};
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX handshake, SRAM return buffering, WB select.
// Define MEM_LD_EXT_EN to add es_mem_op and sub-word load extension.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                ms_allowin,
  input  logic                es2ms_valid,
  input  logic [XLEN-1:0]     es_pc,
  input  logic [ZIP_ES_W-1:0] es_rf_zip,
`ifdef MEM_LD_EXT_EN
  input  logic [2:0]          es_mem_op,
`endif
  input  logic [XLEN-1:0]     data_sram_rdata,
  output logic                ms2ws_valid,
  input  logic                ws_allowin,
  output logic [XLEN-1:0]     ms_pc,
  output logic [ZIP_MS_W-1:0] ms_rf_zip
);

  logic            ms_valid;
  logic            ms_ready_go;
  logic            first_cyc;
  logic            accept;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] rdata_buf;
  logic [XLEN-1:0] word_data;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] final_wdata;
  logic [RF_AW-1:0] waddr;
  es_zip_t         es_zip;
  es_zip_t         ms_r;
  ms_zip_t         ms_out;
`ifdef MEM_LD_EXT_EN
  logic [2:0]      mem_op_r;
`endif

  assign es_zip      = es_rf_zip;
  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go;
  assign accept      = es2ms_valid & ms_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      first_cyc <= 1'b0;
      rdata_buf <= '0;
      pc_r      <= '0;
      ms_r      <= '0;
`ifdef MEM_LD_EXT_EN
      mem_op_r  <= 3'b000;
`endif
    end else begin
      if (ms_allowin) ms_valid <= es2ms_valid;
      first_cyc <= accept;
      if (accept) begin
        pc_r <= es_pc;
        ms_r <= es_zip;
`ifdef MEM_LD_EXT_EN
        mem_op_r <= es_mem_op;
`endif
      end
      // SRAM data is only valid in the first cycle; keep it for stalls
      if (first_cyc & ms_valid & ms_r.res_from_mem)
        rdata_buf <= data_sram_rdata;
    end
  end

  assign word_data = first_cyc ? data_sram_rdata : rdata_buf;

`ifdef MEM_LD_EXT_EN
  mem_ld_align u_align (
    .op   (mem_op_r),
    .addr (ms_r.alu_result[1:0]),
    .word (word_data),
    .data (load_data)
  );
`else
  assign load_data = word_data;
`endif

  assign final_wdata = ms_r.res_from_mem ? load_data : ms_r.alu_result;
  assign waddr       = ms_r.rf_waddr;

  assign ms_out.rf_we    = ms_r.rf_we & ms_valid;
  assign ms_out.rf_waddr = waddr;
  assign ms_out.wdata    = final_wdata;

  assign ms_rf_zip = ms_out;
  assign ms_pc     = pc_r;

endmodule
